// File: rtl/ftq_meta_queue_pkg.sv
// ftq_meta_pkg: shared sizing, pointer type and wrap-around pointer increment for the FTQ meta queue
package ftq_meta_pkg;
    localparam int ENTRIES = 40;
    localparam int WIDTH   = 240;
    localparam int PTR_W   = 6;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(ENTRIES - 1)) ? '0 : p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/ftq_meta_queue_if.sv
// ftq_meta_if: enqueue/dequeue handshake, flush and occupancy between the queue and its users
interface ftq_meta_if #(
    parameter int WIDTH = ftq_meta_pkg::WIDTH,
    parameter int PTR_W = ftq_meta_pkg::PTR_W
);
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             flush;
    logic [PTR_W-1:0] count;

    modport master (
        output enq_valid, enq_data, deq_ready, flush,
        input  enq_ready, deq_valid, deq_data, count
    );
    modport slave (
        input  enq_valid, enq_data, deq_ready, flush,
        output enq_ready, deq_valid, deq_data, count
    );
endinterface

// File: rtl/ftq_meta_queue_stage.sv
// ftq_meta_stage: 2-entry registered FIFO holding memory read data in front of the consumer
module ftq_meta_stage #(
    parameter int WIDTH = ftq_meta_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] tail;
    logic [1:0]       lvl;

    assign lvl = count - 2'(pop);

    // pop shifts the tail forward; a push lands in the first free slot after the pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= lvl + 2'(push);
            head  <= (push && lvl == 2'd0) ? din : (pop && count == 2'd2) ? tail : head;
            tail  <= (push && lvl == 2'd1) ? din : tail;
        end
    end
endmodule

// File: rtl/ftq_meta_queue.sv
// ftq_meta_queue: meta FIFO over an external 1W1R memory, prefetching into a 2-entry output stage
module ftq_meta_queue #(
    parameter int ENTRIES = ftq_meta_pkg::ENTRIES,
    parameter int WIDTH   = ftq_meta_pkg::WIDTH,
    parameter int PTR_W   = ftq_meta_pkg::PTR_W
) (
    input  logic             clock,
    input  logic             reset,
    ftq_meta_if.slave        bus,
    output logic             mem_W0_en,
    output logic [PTR_W-1:0] mem_W0_addr,
    output logic [WIDTH-1:0] mem_W0_data,
    output logic             mem_R0_en,
    output logic [PTR_W-1:0] mem_R0_addr,
    input  logic [WIDTH-1:0] mem_R0_data
);
    import ftq_meta_pkg::*;

    ptr_t             wr_ptr, rd_ptr;
    logic [PTR_W-1:0] count_q, mem_count;
    logic             inflight, enq_fire, deq_fire, rd_issue;
    logic [1:0]       st_count;
    logic [2:0]       occ;
    logic [WIDTH-1:0] st_head;

    assign bus.enq_ready = reset & (count_q < PTR_W'(ENTRIES)) & ~bus.flush;
    assign bus.deq_valid = (st_count != 2'd0) & ~bus.flush;
    assign bus.deq_data  = st_head;
    assign bus.count     = count_q;
    assign enq_fire      = bus.enq_valid & bus.enq_ready;
    assign deq_fire      = bus.deq_valid & bus.deq_ready;
    assign occ           = 3'(st_count) + 3'(inflight) - 3'(deq_fire);
    assign rd_issue      = (mem_count != '0) & (occ < 3'd2) & ~bus.flush;
    assign mem_W0_en     = enq_fire;
    assign mem_W0_addr   = wr_ptr;
    assign mem_W0_data   = bus.enq_data;
    assign mem_R0_en     = rd_issue;
    assign mem_R0_addr   = rd_ptr;

    // pointers and occupancy; a memory slot is released as soon as its read is issued
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
        end else begin
            wr_ptr    <= enq_fire ? ptr_inc(wr_ptr) : wr_ptr;
            rd_ptr    <= rd_issue ? ptr_inc(rd_ptr) : rd_ptr;
            count_q   <= count_q + PTR_W'(enq_fire) - PTR_W'(deq_fire);
            mem_count <= mem_count + PTR_W'(enq_fire) - PTR_W'(rd_issue);
            inflight  <= rd_issue;
        end
    end

    ftq_meta_stage #(.WIDTH(WIDTH)) u_stage (
        .clock (clock),
        .reset (reset),
        .flush (bus.flush),
        .push  (inflight),
        .pop   (deq_fire),
        .din   (mem_R0_data),
        .head  (st_head),
        .count (st_count)
    );
endmodule

// File: tb/tb_ftq_meta_queue.sv
// tb_ftq_meta_queue: directed stimulus with a sequence-number/timestamp reference model and external memory
module tb_ftq_meta_queue;
    import ftq_meta_pkg::*;

    typedef logic [WIDTH-1:0] data_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             mem_w_en, mem_r_en;
    logic [PTR_W-1:0] mem_w_addr, mem_r_addr;
    data_t            mem_w_data, mem_r_data;
    data_t            mem [0:63];
    int               n_cmp = 0, n_bad = 0, cyc = 0;
    int               n_enq = 0, n_iss = 0, n_deq = 0;
    data_t            dat [0:2047];
    int               iss_cyc [0:2047];
    data_t            a5 = {30{8'hA5}};

    ftq_meta_if bus ();

    ftq_meta_queue dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .mem_W0_en   (mem_w_en),
        .mem_W0_addr (mem_w_addr),
        .mem_W0_data (mem_w_data),
        .mem_R0_en   (mem_r_en),
        .mem_R0_addr (mem_r_addr),
        .mem_R0_data (mem_r_data)
    );

    always #5 clock = ~clock;

    function automatic data_t rnd();
        data_t r = '0;
        for (int i = 0; i < 8; i++) r = {r[WIDTH-33:0], $urandom};
        return r;
    endfunction

    // external memory: one-cycle read latency, garbage on cycles without a read
    always @(posedge clock) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        mem_r_data <= mem_r_en ? mem[mem_r_addr] : rnd();
    end

    task automatic chk(input string nm, input data_t act, input data_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, data_t'(act), data_t'(exp));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // reference model: entries numbered since last reset/flush; read of entry n issues once it
    // was written in an earlier cycle and fewer than two older entries stay undelivered; it is
    // presented two cycles after issue and leaves in order when the consumer takes it
    always @(negedge clock) begin : model
        bit e_rdy, e_dv, e_ef, e_df, e_iss;
        if (!reset) begin
            n_enq = 0;
            n_iss = 0;
            n_deq = 0;
        end
        e_rdy = reset && (n_enq - n_deq) < ENTRIES && !bus.flush;
        e_dv  = reset && !bus.flush && n_deq < n_iss && iss_cyc[n_deq] + 2 <= cyc;
        e_ef  = e_rdy && bus.enq_valid;
        e_df  = e_dv && bus.deq_ready;
        e_iss = reset && !bus.flush && n_iss < n_enq && (n_iss - n_deq - int'(e_df)) < 2;
        chkb("enq_ready", bus.enq_ready, e_rdy);
        chkb("deq_valid", bus.deq_valid, e_dv);
        chk("count", data_t'(bus.count), data_t'(n_enq - n_deq));
        chkb("mem_W0_en", mem_w_en, e_ef);
        chkb("mem_R0_en", mem_r_en, e_iss);
        if (e_ef) begin
            chk("mem_W0_addr", data_t'(mem_w_addr), data_t'(n_enq % ENTRIES));
            chk("mem_W0_data", mem_w_data, bus.enq_data);
        end
        if (e_iss) chk("mem_R0_addr", data_t'(mem_r_addr), data_t'(n_iss % ENTRIES));
        if (e_dv) chk("deq_data", bus.deq_data, dat[n_deq]);
        if (bus.flush) begin
            n_enq = 0;
            n_iss = 0;
            n_deq = 0;
        end else begin
            if (e_ef) begin
                dat[n_enq] = bus.enq_data;
                n_enq++;
            end
            if (e_iss) begin
                iss_cyc[n_iss] = cyc;
                n_iss++;
            end
            if (e_df) n_deq++;
        end
        cyc++;
    end

    initial begin
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b0;
        #1 reset = 1'b0;
        #1;
        chkb("rst_enq_ready", bus.enq_ready, 1'b0);
        chkb("rst_deq_valid", bus.deq_valid, 1'b0);
        chk("rst_count", data_t'(bus.count), '0);
        chk("rst_deq_data", bus.deq_data, '0);
        chkb("rst_mem_W0_en", mem_w_en, 1'b0);
        chkb("rst_mem_R0_en", mem_r_en, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chkb("post_rst_enq_ready", bus.enq_ready, 1'b1);
        chk("post_rst_count", data_t'(bus.count), '0);

        // single entry: visible three cycles after enqueue
        tick(); bus.enq_valid = 1'b1; bus.enq_data = a5; bus.deq_ready = 1'b1;
        tick(); bus.enq_valid = 1'b0; #1;
        chk("single_count_t1", data_t'(bus.count), data_t'(1));
        chkb("single_valid_t1", bus.deq_valid, 1'b0);
        tick(); #1;
        chkb("single_valid_t2", bus.deq_valid, 1'b0);
        tick(); #1;
        chkb("single_valid_t3", bus.deq_valid, 1'b1);
        chk("single_data_t3", bus.deq_data, a5);
        chk("single_count_t3", data_t'(bus.count), data_t'(1));
        tick(); #1;
        chk("single_count_t4", data_t'(bus.count), '0);
        chkb("single_valid_t4", bus.deq_valid, 1'b0);

        // fill to capacity, then dequeue while full
        bus.deq_ready = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            tick(); bus.enq_valid = 1'b1; bus.enq_data = data_t'(i);
        end
        tick(); bus.deq_ready = 1'b1; #1;
        chkb("full_enq_ready", bus.enq_ready, 1'b0);
        chk("full_count", data_t'(bus.count), data_t'(40));
        chkb("full_deq_valid", bus.deq_valid, 1'b1);
        chk("full_head", bus.deq_data, '0);
        tick(); bus.enq_valid = 1'b0; #1;
        chk("full_count_after_deq", data_t'(bus.count), data_t'(39));
        chkb("full_reopen", bus.enq_ready, 1'b1);
        repeat (45) tick();
        #1 chk("drain_count", data_t'(bus.count), '0);

        // streaming across the pointer wrap with no bubbles
        for (int i = 0; i < 60; i++) begin
            tick(); bus.enq_valid = 1'b1; bus.enq_data = data_t'(1000 + i); bus.deq_ready = 1'b1;
            if (i >= 3) begin
                #1;
                chkb("wrap_deq_valid", bus.deq_valid, 1'b1);
                chk("wrap_deq_data", bus.deq_data, data_t'(1000 + i - 3));
            end
        end
        tick(); bus.enq_valid = 1'b0;
        repeat (5) tick();
        #1 chk("wrap_count", data_t'(bus.count), '0);

        // alternating backpressure with random offers
        for (int i = 0; i < 80; i++) begin
            tick();
            bus.enq_valid = 1'($urandom_range(0, 1));
            bus.enq_data  = rnd();
            bus.deq_ready = i[0];
        end
        tick(); bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
        repeat (45) tick();
        #1 chk("bp_count", data_t'(bus.count), '0);

        // flush while a read is in flight
        bus.deq_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); bus.enq_valid = 1'b1; bus.enq_data = data_t'(2000 + i);
        end
        tick(); bus.enq_valid = 1'b0;
        repeat (3) tick();
        tick(); bus.deq_ready = 1'b1;
        tick(); bus.flush = 1'b1; #1;
        chkb("flush_enq_ready", bus.enq_ready, 1'b0);
        chkb("flush_deq_valid", bus.deq_valid, 1'b0);
        tick(); bus.flush = 1'b0; bus.enq_valid = 1'b1; bus.enq_data = data_t'(32'h77); #1;
        chk("flush_count", data_t'(bus.count), '0);
        chkb("flush_after_valid", bus.deq_valid, 1'b0);
        tick(); bus.enq_valid = 1'b0; #1;
        chkb("flush_t1_valid", bus.deq_valid, 1'b0);
        tick(); #1;
        chkb("flush_t2_valid", bus.deq_valid, 1'b0);
        tick(); #1;
        chkb("flush_t3_valid", bus.deq_valid, 1'b1);
        chk("flush_t3_data", bus.deq_data, data_t'(32'h77));
        tick(); #1;
        chk("flush_end_count", data_t'(bus.count), '0);

        // asynchronous reset in the middle of traffic
        bus.deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); bus.enq_valid = 1'b1; bus.enq_data = data_t'(3000 + i);
        end
        tick(); #2 reset = 1'b0; #1;
        chkb("arst_enq_ready", bus.enq_ready, 1'b0);
        chkb("arst_deq_valid", bus.deq_valid, 1'b0);
        chk("arst_count", data_t'(bus.count), '0);
        chk("arst_deq_data", bus.deq_data, '0);
        chkb("arst_mem_W0_en", mem_w_en, 1'b0);
        chkb("arst_mem_R0_en", mem_r_en, 1'b0);
        bus.enq_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1; #1;
        chkb("restart_enq_ready", bus.enq_ready, 1'b1);
        chk("restart_count", data_t'(bus.count), '0);
        tick(); bus.enq_valid = 1'b1; bus.enq_data = data_t'(32'h55); bus.deq_ready = 1'b1;
        tick(); bus.enq_valid = 1'b0;
        repeat (2) tick();
        #1;
        chkb("restart_valid", bus.deq_valid, 1'b1);
        chk("restart_data", bus.deq_data, data_t'(32'h55));
        tick(); #1;
        chk("restart_end_count", data_t'(bus.count), '0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ftq_meta_queue.md
FTQ_META_QUEUE -- requirements
Module: ftq_meta_queue

Interface
REQ-001 SHALL take parameters: ENTRIES, default 40, queue depth; WIDTH, default 240, meta payload bits; PTR_W, default 6, pointer/count width.
REQ-002 SHALL have ports: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low (0 = in reset); assertion clears all state immediately, deassertion is synchronous to clock.
REQ-004 enq_valid  input  1  producer offers one meta entry.
REQ-005 enq_ready  output  1  queue accepts an entry this cycle.
REQ-006 enq_data  input  WIDTH  meta payload.
REQ-007 deq_valid  output  1  head entry available on deq_data.
REQ-008 deq_ready  input  1  consumer takes head entry.
REQ-009 deq_data  output  WIDTH  head entry payload, registered.
REQ-010 flush  input  1  synchronous clear of all queued entries.
REQ-011 count  output  PTR_W  occupancy, 0..ENTRIES.
REQ-012 mem_W0_en / mem_W0_addr / mem_W0_data  output  1 / PTR_W / WIDTH  write port of the external 40x240 meta memory.
REQ-013 mem_R0_en / mem_R0_addr  output  1 / PTR_W  read port request; mem_R0_data  input  WIDTH  read data, valid exactly one cycle after mem_R0_en, undefined otherwise.

Function
REQ-014 Enqueue fire = enq_valid & enq_ready; SHALL drive mem_W0_en=1, mem_W0_addr=wr_ptr, mem_W0_data=enq_data combinationally in the same cycle.
REQ-015 enq_ready SHALL equal (count < ENTRIES) & ~flush.
REQ-016 count SHALL cover entries in memory, in-flight reads, and staged entries; +1 on enqueue fire, -1 on dequeue fire, unchanged when both fire.
REQ-017 wr_ptr and rd_ptr SHALL increment modulo ENTRIES (39 -> 0); a memory slot is freed when its read is issued.
REQ-018 Read issue SHALL occur when mem_count > 0 & (staged + inflight - deq_fire) < 2 & ~flush; drives mem_R0_en=1, mem_R0_addr=rd_ptr; only entries written in an earlier cycle are readable (no same-cycle write/read bypass).
REQ-019 inflight flag SHALL be set on read issue; next cycle mem_R0_data SHALL be captured into the 2-entry staging buffer in FIFO order; mem_R0_data SHALL never be sampled when inflight=0.
REQ-020 deq_valid SHALL be 1 iff staging buffer non-empty and flush=0; deq_data = oldest staged entry; dequeue fire = deq_valid & deq_ready.
REQ-021 Latency enqueue fire (cycle t) to deq_valid SHALL be 3 cycles on an empty queue; sustained throughput 1 entry/cycle when deq_ready=1.
REQ-022 deq_data SHALL hold stable while deq_valid=1 and deq_ready=0.
REQ-023 flush SHALL, at the next edge, zero wr_ptr, rd_ptr, count, mem_count, staging buffer, inflight; read data returning after flush discarded; enq/deq fires suppressed during flush.
REQ-024 Full (count=ENTRIES): enq_ready=0; simultaneous dequeue fire does not re-open enq_ready until next cycle.
REQ-025 Empty: deq_valid=0, mem_R0_en=0; enqueue and dequeue never fire on the same entry in the same cycle.

Reset
REQ-026 In reset: wr_ptr=rd_ptr=0, count=0, staging empty, inflight=0, deq_data=0, deq_valid=0, enq_ready=0, mem_W0_en=0, mem_R0_en=0.
REQ-027 First cycle after deassertion: enq_ready=1, count=0.

Structure
REQ-028 ENTRIES, WIDTH, PTR_W, ptr_t typedef and a ptr-increment-with-wrap function SHALL live in shared package ftq_meta_pkg.
REQ-029 Staging buffer SHALL be sub-module ftq_meta_stage (2-entry registered FIFO, push/pop/count); memory macro instantiated by the parent, not inside this block.

Verification
REQ-030 Single entry: enq 0xA5..A5 at t, deq_ready=1 -> deq_valid at t+3, deq_data=0xA5..A5, count 1 -> 0.
REQ-031 Fill: 40 back-to-back enqs, deq_ready=0 -> count=40, enq_ready=0 at 41st; drain yields entries 0..39 in order.
REQ-032 Wrap: 60 streaming enq/deq with deq_ready=1 -> pointers pass 39->0, no gap after fill, data order preserved.
REQ-033 Backpressure: toggle deq_ready every cycle with random enq -> deq_data stable while stalled, no loss/duplication.
REQ-034 Flush with read in flight (10 queued) -> next cycle count=0, deq_valid=0; returning read ignored; next enq emerges 3 cycles later.
REQ-035 Async reset asserted mid-stream -> all outputs at REQ-026 values without clock edge; clean restart after release.
